// File: rtl/aes192_req_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes192_sched_pkg
//  Description : Shared types and constants for the AES-192 request scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes192_sched_pkg;

    localparam int STATE_W      = 128;
    localparam int KEY_W        = 192;
    localparam int CORE_LATENCY = 26;
    localparam int WAIT_CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Saturating increment: the watchdog counter must never wrap back to zero.
    function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes192_req_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes192_req_sched_if
//  Description : Requester-side job and response channels of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes192_req_sched_if #(
    parameter int NUM_REQ = 4
);
    import aes192_sched_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*STATE_W-1:0] req_state;
    logic [NUM_REQ*KEY_W-1:0]   req_key;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [STATE_W-1:0]         rsp_data;
    logic                       rsp_err;

    modport master (
        output req_valid, req_state, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_state, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/aes192_req_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick of the first request at or
//                after ptr, wrapping modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire  [NUM_REQ-1:0] req,
    input  wire  [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found        = 1'b1;
                grant[w_idx]   = 1'b1;
                grant_idx      = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes192_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes192_req_sched
//  Description : Round-robin scheduler sharing one AES-192 core among NUM_REQ
//                requesters, with a completion watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes192_req_sched
    import aes192_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 40
) (
    input  wire                  clk,
    input  wire                  rst,
    aes192_req_sched_if.slave    bus,
    output logic                 core_start,
    output logic [STATE_W-1:0]   core_state,
    output logic [KEY_W-1:0]     core_key,
    input  wire  [STATE_W-1:0]   core_out,
    input  wire                  core_out_valid,
    output logic                 busy
);

    localparam int                    IDX_W          = $clog2(NUM_REQ);
    localparam logic [WAIT_CNT_W-1:0] c_timeout_last = WAIT_CNT_W'(TIMEOUT - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [NUM_REQ-1:0]    w_grant;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_accept;
    logic                  w_done_ok;
    logic                  w_done_to;

    logic                  r_core_start;
    logic [STATE_W-1:0]    r_core_state;
    logic [KEY_W-1:0]      r_core_key;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [STATE_W-1:0]    r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // out_valid is sticky from the previous job during ISSUE, so it is only
    // trusted once the core has been restarted and we are in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ok   = 1'b0;
        w_done_to   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (core_out_valid) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_wait_cnt == c_timeout_last) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_wait_cnt   <= '0;
            r_core_start <= 1'b0;
            r_core_state <= '0;
            r_core_key   <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_core_start <= (w_state_nxt == ISSUE);
            r_busy       <= (w_state_nxt != IDLE);
            r_rsp_valid  <= (w_state_nxt == RESP) ? (NUM_REQ'(1) << r_owner) : '0;

            if (w_accept) begin
                r_core_state <= bus.req_state[w_grant_idx*STATE_W +: STATE_W];
                r_core_key   <= bus.req_key[w_grant_idx*KEY_W +: KEY_W];
                r_owner      <= w_grant_idx;
                r_rr_ptr     <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                      : w_grant_idx + IDX_W'(1);
            end

            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= sat_inc(r_wait_cnt);
            end

            if (w_done_ok) begin
                r_rsp_data <= core_out;
                r_rsp_err  <= 1'b0;
            end else if (w_done_to) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign core_start    = r_core_start;
    assign core_state    = r_core_state;
    assign core_key      = r_core_key;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign busy          = r_busy;

endmodule
`default_nettype wire
